// File: rtl/fetch_prefetch.sv
// fetch_prefetch
//   Instruction fetch front-end for the boot/program ROM (512x32 block RAM
//   with a 1-cycle registered read). It drives one ROM read port, tracks the
//   single read in flight and buffers returned words together with their byte
//   PC in a small shift queue. Decode pops the queue head through a
//   valid/ready handshake. Branch/jump redirects flush everything and restart
//   fetch. An illegal fetch PC halts the block in a FAULT state.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   rom_en_o       ROM read enable (one word per cycle at most)
//   rom_addr_o     ROM word index of the current fetch PC
//   rom_data_i     ROM read data, valid the cycle after rom_en_o
//   redirect_i     load redirect_pc_i as the new fetch PC, flush queue and read
//   redirect_pc_i  byte address to redirect to
//   inst_valid_o   queue head holds an instruction
//   inst_o         queue head instruction word
//   inst_pc_o      byte PC of the queue head
//   inst_ready_i   decode accepts the head this cycle
//   fault_o        fetch halted on a misaligned or out-of-window PC
module fetch_prefetch #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_pc_o,
  input  logic              inst_ready_i,
  output logic              fault_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e            state_q;
  logic [31:0]       fetchPc_q;
  logic              inflight_q;
  logic [31:0]       inflightPc_q;
  logic [CNT_W-1:0]  count_q;
  logic [31:0]       qInst_q [DEPTH];
  logic [31:0]       qPc_q   [DEPTH];

  logic              fetchLegal;
  logic              redirectLegal;
  logic              pop;
  logic              push;
  logic              issue;
  int                occupancy;
  int                pushIdx;

  // A PC is fetchable only if word aligned and inside the ROM window; the
  // window check compares every address bit above the word index, so the
  // fetch PC stepping one word past the end becomes illegal instead of
  // wrapping back to word 0.
  assign fetchLegal    = (fetchPc_q[1:0] == 2'b00) &&
                         (fetchPc_q[31:ADDR_W+2] == ROM_BASE[31:ADDR_W+2]);
  assign redirectLegal = (redirect_pc_i[1:0] == 2'b00) &&
                         (redirect_pc_i[31:ADDR_W+2] == ROM_BASE[31:ADDR_W+2]);

  // Handshake and issue decisions. A read is only issued if, counting the
  // word already in flight and the word leaving this cycle, the queue still
  // has room for it when it returns; that is what keeps the queue from ever
  // overflowing. Reset and redirect both suppress pop, push and issue.
  always_comb begin
    pop       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    occupancy = 0;
    pushIdx   = 0;
    pop       = inst_valid_o & inst_ready_i & ~redirect_i & ~rst_i;
    push      = inflight_q & ~redirect_i & ~rst_i;
    occupancy = int'(count_q) + int'(inflight_q) - int'(pop);
    pushIdx   = int'(count_q) - int'(pop);
    issue     = ~rst_i & ~redirect_i & (state_q == ST_RUN) & fetchLegal &
                (occupancy < int'(DEPTH));
  end

  // The ROM samples its address on the same edge as our issue, so enable and
  // address come straight from the current fetch PC. Entry 0 of the shift
  // queue is the head, so the instruction outputs are plain register reads.
  assign rom_en_o     = issue;
  assign rom_addr_o   = rst_i ? '0 : fetchPc_q[ADDR_W+1:2];
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = qInst_q[0];
  assign inst_pc_o    = qPc_q[0];
  assign fault_o      = (state_q == ST_FAULT);

  // Fetch state machine, in-flight tracking and prefetch queue. A redirect
  // overrides everything except reset: it empties the queue, drops the word
  // returning this cycle and either restarts fetch or parks in FAULT. In
  // normal operation the queue shifts down on a pop, and a returning word is
  // written into the first free slot after that shift. RUN drops into FAULT
  // only once the fetch PC is illegal and nothing is left queued or pending,
  // so words fetched before the end of the window still drain to decode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      fetchPc_q    <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        qInst_q[i] <= '0;
        qPc_q[i]   <= '0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflightPc_q <= fetchPc_q;
      end
      if (redirect_i) begin
        count_q   <= '0;
        fetchPc_q <= redirect_pc_i;
        state_q   <= redirectLegal ? ST_RUN : ST_FAULT;
      end else begin
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        if (issue) begin
          fetchPc_q <= fetchPc_q + 32'd4;
        end
        if ((state_q == ST_RUN) && !fetchLegal && (count_q == '0) && !inflight_q) begin
          state_q <= ST_FAULT;
        end
        if (pop) begin
          for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            qInst_q[i] <= qInst_q[i+1];
            qPc_q[i]   <= qPc_q[i+1];
          end
        end
        if (push) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == pushIdx) begin
              qInst_q[i] <= rom_data_i;
              qPc_q[i]   <= inflightPc_q;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch
//   Bench for fetch_prefetch with the default 512-word ROM window at address 0
//   and a two-entry queue. The ROM is modelled as a registered read returning
//   A0000000 | word index. Directed sequences pin down the cycle timing of
//   start-up, stall, redirect, fault and end-of-window behaviour; a random
//   phase then drives ready, redirects and resets. A transaction-level
//   reference tracks which PC decode should receive next and when the fetch
//   unit must be halted.
module tb_fetch_prefetch;

  localparam int          ADDR_W   = 9;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk;
  logic              rst;
  logic              romEn;
  logic [ADDR_W-1:0] romAddr;
  logic [31:0]       romData;
  logic              redirect;
  logic [31:0]       redirectPc;
  logic              instValid;
  logic [31:0]       inst;
  logic [31:0]       instPc;
  logic              instReady;
  logic              fault;

  int checkCount;
  int errorCount;

  logic [31:0] expPc;
  bit          modelLive;
  bit          prevRst;
  bit          prevRedirect;
  bit          prevStall;
  int          illegalAge;
  logic [31:0] prevInst;
  logic [31:0] prevPc;

  fetch_prefetch #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .ROM_BASE(ROM_BASE),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rom_en_o     (romEn),
    .rom_addr_o   (romAddr),
    .rom_data_i   (romData),
    .redirect_i   (redirect),
    .redirect_pc_i(redirectPc),
    .inst_valid_o (instValid),
    .inst_o       (inst),
    .inst_pc_o    (instPc),
    .inst_ready_i (instReady),
    .fault_o      (fault)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM: one-cycle registered read, every word tagged with its own index.
  always @(posedge clk) begin
    if (romEn) begin
      romData <= 32'hA000_0000 | 32'(romAddr);
    end
  end

  function automatic bit pcLegal(input logic [31:0] pc);
    return ((pc & 32'd3) == 32'd0) && (pc >= ROM_BASE) &&
           ((pc - ROM_BASE) < (32'd4 << ADDR_W));
  endfunction

  function automatic logic [31:0] romWord(input logic [31:0] pc);
    return 32'hA000_0000 | ((pc - ROM_BASE) >> 2);
  endfunction

  function automatic logic [31:0] randomPc();
    int unsigned sel;
    int unsigned words;
    sel   = $urandom_range(0, 5);
    words = 32'd1 << ADDR_W;
    case (sel)
      0, 1:    return ROM_BASE + ($urandom_range(0, words - 1) << 2);
      2:       return ROM_BASE + ((words - 4 + $urandom_range(0, 3)) << 2);
      3:       return ROM_BASE + ($urandom_range(0, words - 1) << 2) + $urandom_range(1, 3);
      4:       return ROM_BASE + (words << 2) + ($urandom_range(0, 1023) << 2);
      default: return RESET_PC;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, sample mid-cycle, run
  // the reference checks, then advance the reference.
  task automatic applyStimulus(input bit r, input bit redir, input logic [31:0] rpc,
                               input bit rdy);
    bit popNow;
    @(posedge clk);
    #1;
    rst        = r;
    redirect   = redir;
    redirectPc = rpc;
    instReady  = rdy;
    #4;
    popNow = 1'b0;
    if (modelLive) begin
      if (prevRst) begin
        checkOutput("postResetValid", 32'(instValid), 32'd0);
        checkOutput("postResetFault", 32'(fault), 32'd0);
      end else if (prevRedirect) begin
        checkOutput("postRedirectValid", 32'(instValid), 32'd0);
      end
      if (prevStall) begin
        checkOutput("stallValid", 32'(instValid), 32'd1);
        checkOutput("stallInst", inst, prevInst);
        checkOutput("stallPc", instPc, prevPc);
      end
      if (pcLegal(expPc)) begin
        checkOutput("faultWhileLegal", 32'(fault), 32'd0);
      end else if (illegalAge >= 2) begin
        checkOutput("faultWhenDrained", 32'(fault), 32'd1);
        checkOutput("validInFault", 32'(instValid), 32'd0);
      end
      if (redir) begin
        checkOutput("romEnOnRedirect", 32'(romEn), 32'd0);
      end
      if (fault) begin
        checkOutput("romEnInFault", 32'(romEn), 32'd0);
      end
      popNow = !r && !redir && (instValid === 1'b1) && rdy;
      if (popNow) begin
        checkOutput("popPc", instPc, expPc);
        checkOutput("popInst", inst, romWord(expPc));
      end
    end
    if (r) begin
      modelLive  = 1'b1;
      expPc      = RESET_PC;
      illegalAge = 0;
    end else if (modelLive) begin
      if (redir) begin
        expPc      = rpc;
        illegalAge = pcLegal(rpc) ? 0 : 1;
      end else begin
        if (popNow) begin
          expPc = expPc + 32'd4;
        end
        illegalAge = pcLegal(expPc) ? 0 : ((illegalAge < 100) ? illegalAge + 1 : illegalAge);
      end
    end
    prevRst      = r;
    prevRedirect = redir && !r;
    prevStall    = modelLive && !r && !redir && (instValid === 1'b1) && !rdy;
    prevInst     = inst;
    prevPc       = instPc;
  endtask

  // First four cycles after reset release: issue in cycle 0, data in cycle 2.
  task automatic checkRestart();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c0RomEn", 32'(romEn), 32'd1);
    checkOutput("c0RomAddr", 32'(romAddr), 32'd0);
    checkOutput("c0Valid", 32'(instValid), 32'd0);
    checkOutput("c0Fault", 32'(fault), 32'd0);
    checkOutput("c0Inst", inst, 32'h0);
    checkOutput("c0InstPc", instPc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c1RomEn", 32'(romEn), 32'd1);
    checkOutput("c1RomAddr", 32'(romAddr), 32'd1);
    checkOutput("c1Valid", 32'(instValid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c2Valid", 32'(instValid), 32'd1);
    checkOutput("c2Inst", inst, 32'hA000_0000);
    checkOutput("c2InstPc", instPc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c3Valid", 32'(instValid), 32'd1);
    checkOutput("c3Inst", inst, 32'hA000_0001);
    checkOutput("c3InstPc", instPc, 32'h4);
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    modelLive    = 1'b0;
    prevRst      = 1'b0;
    prevRedirect = 1'b0;
    prevStall    = 1'b0;
    illegalAge   = 0;
    expPc        = RESET_PC;
    prevInst     = '0;
    prevPc       = '0;
    rst          = 1'b1;
    redirect     = 1'b0;
    redirectPc   = '0;
    instReady    = 1'b0;

    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    // Start-up latency and first two words.
    checkRestart();

    // Streaming at one word per cycle, then a five-cycle stall.
    for (int c = 4; c <= 9; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("streamValid", 32'(instValid), 32'd1);
    end
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("stallRomEn", 32'(romEn), 32'd0);
      checkOutput("stallHeadPc", instPc, 32'h20);
      checkOutput("stallHeadInst", inst, 32'hA000_0008);
    end
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x40 mid-stream.
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redirRomEn", 32'(romEn), 32'd1);
    checkOutput("redirRomAddr", 32'(romAddr), 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redirGapValid", 32'(instValid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redirValid", 32'(instValid), 32'd1);
    checkOutput("redirInst", inst, 32'hA000_0010);
    checkOutput("redirInstPc", instPc, 32'h40);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // Misaligned and out-of-window redirects, then recovery.
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("misalignFault", 32'(fault), 32'd1);
    checkOutput("misalignRomEn", 32'(romEn), 32'd0);
    checkOutput("misalignValid", 32'(instValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h800, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("outOfWindowFault", 32'(fault), 32'd1);
    checkOutput("outOfWindowRomEn", 32'(romEn), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("recoverFault", 32'(fault), 32'd0);
    checkOutput("recoverRomEn", 32'(romEn), 32'd1);
    checkOutput("recoverRomAddr", 32'(romAddr), 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("recoverInst", inst, 32'hA000_0004);
    checkOutput("recoverInstPc", instPc, 32'h10);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    // End of window: last two words drain, then halt without wrapping.
    applyStimulus(1'b0, 1'b1, 32'h7F8, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("endRomAddr0", 32'(romAddr), 32'h1FE);
    checkOutput("endRomEn0", 32'(romEn), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("endRomAddr1", 32'(romAddr), 32'h1FF);
    checkOutput("endRomEn1", 32'(romEn), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("endRomEn2", 32'(romEn), 32'd0);
    checkOutput("endInst0", inst, 32'hA000_01FE);
    checkOutput("endInstPc0", instPc, 32'h7F8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("endRomEn3", 32'(romEn), 32'd0);
    checkOutput("endInst1", inst, 32'hA000_01FF);
    checkOutput("endInstPc1", instPc, 32'h7FC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("endRomEn4", 32'(romEn), 32'd0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("endFault", 32'(fault), 32'd1);
      checkOutput("endRomEnHalted", 32'(romEn), 32'd0);
    end

    // Reset mid-stream with a read in flight, then a clean restart.
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkRestart();

    // Random traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      bit          r;
      bit          d;
      bit          rdy;
      logic [31:0] p;
      r   = ($urandom_range(0, 199) == 0);
      d   = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      p   = randomPc();
      applyStimulus(r, d, p, rdy);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
